// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern source behind the VGA timing generator, 2-cycle aligned RGB/de/hs/vs
// Ports:
//   in_pclk, in_rstn            pixel clock, asynchronous active-low reset
//   in_x, in_y                  active pixel / line index from the timing generator
//   in_valid, in_de             pixel strobe, data enable
//   in_hs, in_vs                syncs, active low
//   in_pattern_sel              requested pattern, taken only at frame start (in_vs falling)
//   in_solid_rgb                {R,G,B} for the solid pattern
//   out_data                    {R,G,B}, zero whenever the delayed de or valid is low
//   out_valid/out_de/out_hs/out_vs  inputs delayed by 2 cycles
//   out_frame_cnt               frames started since reset, wraps at 255
module vga_pattern_gen #(
  parameter int PW          = 14,
  parameter int BPC         = 8,
  parameter int H_ActivePix = 640,
  parameter int V_ActivePix = 480,
  parameter int CHECK_LOG2  = 4
) (
  input  logic               in_pclk,
  input  logic               in_rstn,
  input  logic [PW-1:0]      in_x,
  input  logic [11:0]        in_y,
  input  logic               in_valid,
  input  logic               in_de,
  input  logic               in_hs,
  input  logic               in_vs,
  input  logic [2:0]         in_pattern_sel,
  input  logic [3*BPC-1:0]   in_solid_rgb,
  output logic [3*BPC-1:0]   out_data,
  output logic               out_valid,
  output logic               out_de,
  output logic               out_hs,
  output logic               out_vs,
  output logic [7:0]         out_frame_cnt
);
  localparam int BW = H_ActivePix / 8;
  localparam logic [PW-1:0] BW_M1  = PW'(BW - 1);
  localparam logic [PW-1:0] H_LAST = PW'(H_ActivePix - 1);
  localparam logic [11:0]   V_LAST = 12'(V_ActivePix - 1);

  logic               valid_q, de_q, hs_q, vs_q;
  logic               valid2_q, de2_q, hs2_q, vs2_q;
  logic [2:0]         pat_q, pat_d, pat1_q;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [PW-1:0]      pix_cnt_q, pix_cnt_d;
  logic [2:0]         bar_idx_q, bar_idx_d, bar1_q;
  logic [BPC-1:0]     hramp_q, vramp_q;
  logic               check_q, line_q, border_q;
  logic [3*BPC-1:0]   solid_q, colour, data_d, data_q;
  logic               frame_start, bar_end;

  // vs_q doubles as the registered copy of in_vs used for edge detection
  assign frame_start = vs_q & ~in_vs;
  assign pat_d       = frame_start ? in_pattern_sel : pat_q;
  assign frame_cnt_d = frame_cnt_q + 8'(frame_start);
  assign bar_end     = pix_cnt_q == BW_M1;

  always_comb begin
    pix_cnt_d = !in_de ? '0 : !in_valid ? pix_cnt_q : bar_end ? '0 : pix_cnt_q + 1'b1;
    bar_idx_d = !in_de ? 3'd0 : (in_valid && bar_end && bar_idx_q != 3'd7) ? bar_idx_q + 3'd1 : bar_idx_q;
  end

  // colour bars: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars
  always_comb begin
    colour = {{BPC{~bar1_q[1]}}, {BPC{~bar1_q[2]}}, {BPC{~bar1_q[0]}}};
    case (pat1_q)
      3'd1: colour = {3{hramp_q}};
      3'd2: colour = {3{vramp_q}};
      3'd3: colour = {3*BPC{check_q}};
      3'd4: colour = solid_q;
      3'd5: colour = {3*BPC{line_q}};
      3'd6: colour = {3*BPC{border_q}};
      default: ;
    endcase
    data_d = (de_q && valid_q) ? colour : '0;
  end

  // stage 1 captures the pattern in force before any latch on this cycle,
  // so a pixel coinciding with frame start still uses the old pattern
  always_ff @(posedge in_pclk or negedge in_rstn) begin
    if (!in_rstn) begin
      valid_q     <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      valid2_q    <= 1'b0;
      de2_q       <= 1'b0;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      pat_q       <= '0;
      pat1_q      <= '0;
      frame_cnt_q <= '0;
      pix_cnt_q   <= '0;
      bar_idx_q   <= '0;
      bar1_q      <= '0;
      hramp_q     <= '0;
      vramp_q     <= '0;
      check_q     <= 1'b0;
      line_q      <= 1'b0;
      border_q    <= 1'b0;
      solid_q     <= '0;
      data_q      <= '0;
    end else begin
      valid_q     <= in_valid;
      de_q        <= in_de;
      hs_q        <= in_hs;
      vs_q        <= in_vs;
      valid2_q    <= valid_q;
      de2_q       <= de_q;
      hs2_q       <= hs_q;
      vs2_q       <= vs_q;
      pat_q       <= pat_d;
      pat1_q      <= pat_q;
      frame_cnt_q <= frame_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      bar_idx_q   <= bar_idx_d;
      bar1_q      <= bar_idx_q;
      hramp_q     <= in_x[BPC-1:0];
      vramp_q     <= in_y[BPC-1:0];
      check_q     <= in_x[CHECK_LOG2] ^ in_y[CHECK_LOG2];
      line_q      <= in_x[7:0] == frame_cnt_q;
      border_q    <= in_x == '0 || in_x == H_LAST || in_y == '0 || in_y == V_LAST;
      solid_q     <= in_solid_rgb;
      data_q      <= data_d;
    end
  end

  assign out_data      = data_q;
  assign out_valid     = valid2_q;
  assign out_de        = de2_q;
  assign out_hs        = hs2_q;
  assign out_vs        = vs2_q;
  assign out_frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench for vga_pattern_gen with directed lines and frames
module tb_vga_pattern_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] in_x = '0;
  logic [11:0] in_y = '0;
  logic        in_valid = 1'b0, in_de = 1'b0, in_hs = 1'b1, in_vs = 1'b1;
  logic [2:0]  in_pattern_sel = '0;
  logic [23:0] in_solid_rgb = '0;
  logic [23:0] out_data;
  logic        out_valid, out_de, out_hs, out_vs;
  logic [7:0]  out_frame_cnt;

  int total = 0;
  int bad = 0;
  int nframes = 0;
  logic [2:0] m_pat = '0;
  logic [7:0] m_fc = '0;
  logic       m_vs_prev = 1'b1;
  logic [27:0] q[$];

  localparam logic [23:0] W = 24'hFFFFFF;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_pattern_gen dut (
    .in_pclk(clk), .in_rstn(rst_n), .in_x(in_x), .in_y(in_y), .in_valid(in_valid),
    .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .in_pattern_sel(in_pattern_sel),
    .in_solid_rgb(in_solid_rgb), .out_data(out_data), .out_valid(out_valid),
    .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .out_frame_cnt(out_frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model(input logic [2:0] p, input logic [13:0] x,
                                        input logic [11:0] y, input logic [23:0] s, input logic [7:0] f);
    int b;
    b = x / 80;
    if (b > 7) b = 7;
    case (p)
      3'd1: return {3{x[7:0]}};
      3'd2: return {3{y[7:0]}};
      3'd3: return (x[4] ^ y[4]) ? W : 24'h0;
      3'd4: return s;
      3'd5: return (x[7:0] == f) ? W : 24'h0;
      3'd6: return (x == 0 || x == 639 || y == 0 || y == 479) ? W : 24'h0;
      default: return BARS[b];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [13:0] x, input logic [11:0] y, input logic v, input logic de,
                     input logic hs, input logic vs);
    logic [23:0] d;
    @(posedge clk);
    #1;
    in_x = x; in_y = y; in_valid = v; in_de = de; in_hs = hs; in_vs = vs;
    d = (v && de) ? model(m_pat, x, y, in_solid_rgb, m_fc) : 24'h0;
    q.push_back({v, de, hs, vs, d});
    if (m_vs_prev && !vs) begin
      m_pat = in_pattern_sel;
      m_fc++;
      nframes++;
    end
    m_vs_prev = vs;
  endtask

  task automatic frame();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
  endtask

  task automatic line(input logic [11:0] y, input int x0, input int n);
    cyc(0, y, 0, 0, 0, 1);
    cyc(0, y, 0, 0, 0, 1);
    cyc(0, y, 0, 0, 1, 1);
    for (int i = 0; i < n; i++) cyc(14'(x0 + i), y, 1, 1, 1, 1);
    cyc(0, y, 0, 0, 1, 1);
  endtask

  // each cycle's expectation is pushed as its input is driven; the output
  // for it is visible two edges later, when two newer entries are queued
  always @(negedge clk) begin
    logic [27:0] e;
    if (rst_n && q.size() > 2) begin
      e = q.pop_front();
      total++;
      if ({out_valid, out_de, out_hs, out_vs, out_data} !== e) begin
        bad++;
        $display("FAIL pixel got v/de/hs/vs=%b%b%b%b data=%h exp v/de/hs/vs=%b data=%h",
                 out_valid, out_de, out_hs, out_vs, out_data, e[27:24], e[23:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_de = ~in_de;
      in_valid = ~in_valid;
      in_hs = ~in_hs;
      in_vs = ~in_vs;
      #1;
      chk("rst_de", out_de, 0);
      chk("rst_hs", out_hs, 1);
      chk("rst_vs", out_vs, 1);
      chk("rst_data", out_data, 0);
      chk("rst_cnt", out_frame_cnt, 0);
    end
    in_de = 0; in_valid = 0; in_hs = 1; in_vs = 1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    in_pattern_sel = 3'd0;
    frame();
    line(0, 0, 640);
    in_pattern_sel = 3'd3;
    line(1, 0, 640);
    frame();
    line(0, 0, 48);
    line(16, 0, 48);
    in_pattern_sel = 3'd1;
    frame();
    line(5, 0, 320);
    in_pattern_sel = 3'd2;
    frame();
    line(12'h37, 0, 8);
    in_solid_rgb = 24'h123456;
    in_pattern_sel = 3'd4;
    frame();
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) cyc(14'(i / 2), 3, (i % 2) == 0, 1, i > 28, 1);
    cyc(0, 0, 0, 0, 1, 1);
    in_pattern_sel = 3'd6;
    frame();
    line(0, 0, 4);
    line(100, 0, 4);
    line(100, 636, 4);
    line(479, 300, 4);
    line(478, 637, 3);
    in_pattern_sel = 3'd7;
    frame();
    line(9, 0, 640);
    while (nframes < 257) frame();
    cyc(0, 0, 0, 0, 1, 1);
    chk("frame_cnt_wrap", out_frame_cnt, 8'd1);
    in_pattern_sel = 3'd5;
    while (nframes < 266) frame();
    cyc(0, 0, 0, 0, 1, 1);
    chk("frame_cnt_10", out_frame_cnt, 8'd10);
    line(2, 0, 640);
    cyc(0, 4, 0, 0, 0, 1);
    cyc(0, 4, 0, 0, 1, 1);
    for (int i = 0; i < 100; i++) cyc(14'(i), 4, 1, 1, 1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_de", out_de, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_hs", out_hs, 1);
    chk("midrst_vs", out_vs, 1);
    chk("midrst_data", out_data, 0);
    chk("midrst_cnt", out_frame_cnt, 0);
    q.delete();
    in_de = 0; in_valid = 0; in_hs = 1; in_vs = 1;
    m_pat = '0; m_fc = '0; m_vs_prev = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    line(7, 0, 200);
    frame();
    cyc(0, 0, 0, 0, 1, 1);
    chk("cnt_after_rst", out_frame_cnt, 8'd1);
    line(8, 0, 300);
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
